// File: rtl/turn_switch_encoder_if.sv
// turn_switch_encoder_if: raw switch pins in, request levels and status out
interface turn_switch_encoder_if;
    logic       sw_left;
    logic       sw_right;
    logic       Left;
    logic       Right;
    logic       pending;
    logic [1:0] mode;
    modport master (output sw_left, sw_right, input Left, Right, pending, mode);
    modport slave (input sw_left, sw_right, output Left, Right, pending, mode);
endinterface

// File: rtl/turn_switch_encoder.sv
// turn_switch_encoder: synchronize and debounce turn switches, merge near-coincident presses into hazard
module turn_switch_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PAIR_WINDOW = 3
) (
    input logic clk,
    input logic reset,
    turn_switch_encoder_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WW = $clog2(PAIR_WINDOW + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WW-1:0] W_LAST = WW'(PAIR_WINDOW - 1);
    typedef enum logic [2:0] {IDLE, PAIR_WAIT, LEFT_ACT, RIGHT_ACT, HAZARD_ACT} state_t;
    state_t st, nxt;
    logic [1:0] s1, s2, deb;
    logic [DW-1:0] cnt [2];
    logic side, side_n;
    logic [WW-1:0] win, win_n;
    // bit 0 is the left channel, bit 1 the right channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
            deb <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            s1 <= {bus.sw_right, bus.sw_left};
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == D_LAST) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
    always_comb begin
        nxt = st;
        side_n = side;
        win_n = win;
        case (st)
            IDLE: begin
                if (&deb) nxt = HAZARD_ACT;
                else if (|deb) begin
                    nxt = PAIR_WAIT;
                    side_n = deb[1];
                    win_n = '0;
                end
            end
            PAIR_WAIT: begin
                if (deb[!side]) nxt = HAZARD_ACT;
                else if (!deb[side]) nxt = IDLE;
                else if (win == W_LAST) nxt = side ? RIGHT_ACT : LEFT_ACT;
                else win_n = win + 1'b1;
            end
            default: nxt = (deb == 2'b00) ? IDLE : st;
        endcase
    end
    // outputs are registered from the next state so they track the state register exactly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= IDLE;
            side <= 1'b0;
            win <= '0;
            bus.Left <= 1'b0;
            bus.Right <= 1'b0;
            bus.pending <= 1'b0;
            bus.mode <= 2'b00;
        end else begin
            st <= nxt;
            side <= side_n;
            win <= win_n;
            bus.Left <= nxt == LEFT_ACT || nxt == HAZARD_ACT;
            bus.Right <= nxt == RIGHT_ACT || nxt == HAZARD_ACT;
            bus.pending <= nxt == PAIR_WAIT;
            bus.mode <= nxt == LEFT_ACT ? 2'b01 : nxt == RIGHT_ACT ? 2'b10 : nxt == HAZARD_ACT ? 2'b11 : 2'b00;
        end
    end
endmodule

// File: tb/tb_turn_switch_encoder.sv
// tb_turn_switch_encoder: directed per-cycle vectors for the turn switch encoder at D=4, W=3
module tb_turn_switch_encoder;
    typedef struct packed {
        logic       l;
        logic       r;
        logic [4:0] n;
        logic       el;
        logic       er;
        logic       ep;
        logic [1:0] em;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    turn_switch_encoder_if bus();
    turn_switch_encoder #(.DEBOUNCE_CYCLES(4), .PAIR_WINDOW(3)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic check(input string nm, input logic [4:0] want);
        logic [4:0] got;
        got = {bus.Left, bus.Right, bus.pending, bus.mode};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got {L,R,pend,mode}=%b want=%b", nm, $time, got, want);
        end
    endtask
    // hold the switches for n edges, checking outputs 1 time unit after each edge
    task automatic run(input string nm, input logic l, input logic r, input int n,
                       input logic el, input logic er, input logic ep, input logic [1:0] em);
        bus.sw_left = l;
        bus.sw_right = r;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s.e%0d", nm, k), {el, er, ep, em});
        end
    endtask
    task automatic add(input logic l, input logic r, input int n,
                       input logic el, input logic er, input logic ep, input logic [1:0] em);
        vec_t v;
        v.l = l;
        v.r = r;
        v.n = 5'(n);
        v.el = el;
        v.er = er;
        v.ep = ep;
        v.em = em;
        tbl.push_back(v);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
    initial begin
        // single left press, then release
        add(1, 0, 6, 0, 0, 0, 2'b00);
        add(1, 0, 3, 0, 0, 1, 2'b00);
        add(1, 0, 11, 1, 0, 0, 2'b01);
        add(0, 0, 6, 1, 0, 0, 2'b01);
        add(0, 0, 2, 0, 0, 0, 2'b00);
        // bounce 1,0,1,0 then hold high; last rising sample is edge 4
        add(1, 0, 1, 0, 0, 0, 2'b00);
        add(0, 0, 1, 0, 0, 0, 2'b00);
        add(1, 0, 1, 0, 0, 0, 2'b00);
        add(0, 0, 1, 0, 0, 0, 2'b00);
        add(1, 0, 6, 0, 0, 0, 2'b00);
        add(1, 0, 3, 0, 0, 1, 2'b00);
        add(1, 0, 2, 1, 0, 0, 2'b01);
        add(0, 0, 6, 1, 0, 0, 2'b01);
        add(0, 0, 2, 0, 0, 0, 2'b00);
        // 3-cycle pulse never debounces
        add(1, 0, 3, 0, 0, 0, 2'b00);
        add(0, 0, 8, 0, 0, 0, 2'b00);
        // right first, left 2 cycles later: hazard, right never alone
        add(0, 1, 2, 0, 0, 0, 2'b00);
        add(1, 1, 4, 0, 0, 0, 2'b00);
        add(1, 1, 2, 0, 0, 1, 2'b00);
        add(1, 1, 4, 1, 1, 0, 2'b11);
        add(0, 0, 6, 1, 1, 0, 2'b11);
        add(0, 0, 2, 0, 0, 0, 2'b00);
        // late partner does not upgrade LEFT_ACT
        add(1, 0, 6, 0, 0, 0, 2'b00);
        add(1, 0, 3, 0, 0, 1, 2'b00);
        add(1, 0, 1, 1, 0, 0, 2'b01);
        add(1, 1, 10, 1, 0, 0, 2'b01);
        add(0, 1, 10, 1, 0, 0, 2'b01);
        add(0, 0, 6, 1, 0, 0, 2'b01);
        add(0, 0, 2, 0, 0, 0, 2'b00);
        bus.sw_left = 1'b1;
        bus.sw_right = 1'b1;
        #1;
        check("reset_hold_t0", 5'b00000);
        run("reset_hold", 1, 1, 4, 0, 0, 0, 2'b00);
        reset = 1'b1;
        run("post_reset", 1, 1, 6, 0, 0, 0, 2'b00);
        run("post_reset_hz", 1, 1, 2, 1, 1, 0, 2'b11);
        reset = 1'b0;
        #1;
        check("async_reset", 5'b00000);
        @(posedge clk);
        #1;
        check("reset_pulse", 5'b00000);
        reset = 1'b1;
        run("rearm", 1, 1, 6, 0, 0, 0, 2'b00);
        run("rearm_hz", 1, 1, 2, 1, 1, 0, 2'b11);
        run("rearm_rel", 0, 0, 6, 1, 1, 0, 2'b11);
        run("rearm_idle", 0, 0, 2, 0, 0, 0, 2'b00);
        for (int i = 0; i < tbl.size(); i++)
            run($sformatf("vec%0d", i), tbl[i].l, tbl[i].r, int'(tbl[i].n),
                tbl[i].el, tbl[i].er, tbl[i].ep, tbl[i].em);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
